oled_iic_writer: RTL and testbench

- Fixed-format IIC write master for the OLED panel.
- Accepts one 24-bit word {device address, control byte, payload} from the display content generators (font/command sequencers).
- Serialises the word as START, three bytes, STOP on an open-drain SCL/SDA pair, then pulses `write_done` once the bus is free.
- It is the consumer end of the `ShowFont_Data` / `write_done` handshake.

---
 rtl/oled_iic_pkg.sv | 55 +++++
 rtl/oled_iic_tick.sv | 29 ++
 rtl/oled_iic_writer.sv | 146 ++++++++++++++
 tb/tb_oled_iic_writer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_iic_pkg.sv
// Shared definitions for the OLED IIC write path: FSM state codes, symbol phases,
// panel address/control bytes and the per-phase bus level decode.
package oled_iic_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StStart = 3'd1;
  localparam state_t StByte  = 3'd2;
  localparam state_t StAck   = 3'd3;
  localparam state_t StStop  = 3'd4;
  localparam state_t StDone  = 3'd5;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  localparam logic [7:0] OLED_ADDR = 8'h78;
  localparam logic [7:0] CTRL_CMD  = 8'h00;
  localparam logic [7:0] CTRL_DATA = 8'h40;

  // Returns {scl, sda_oe} for a given state, phase and data bit.
  function automatic logic [1:0] bus_levels(input state_t st, input logic [1:0] ph,
                                            input logic dat);
    logic scl;
    logic oe;
    scl = 1'b1;
    oe  = 1'b0;
    case (st)
      StStart: begin
        scl = (ph != PH3);
        oe  = (ph != PH0);
      end
      StByte: begin
        scl = (ph == PH1) || (ph == PH2);
        oe  = ~dat;
      end
      StAck: begin
        scl = (ph == PH1) || (ph == PH2);
        oe  = 1'b0;
      end
      StStop: begin
        scl = (ph != PH0);
        oe  = (ph == PH0) || (ph == PH1);
      end
      default: begin
        scl = 1'b1;
        oe  = 1'b0;
      end
    endcase
    return {scl, oe};
  endfunction

endpackage

// File: rtl/oled_iic_tick.sv
// Quarter-bit strobe: tick is high for one clock every DIV_Q clocks while clr is low.
module oled_iic_tick #(
  parameter int unsigned DIV_Q = 125
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (DIV_Q > 1) ? $clog2(DIV_Q) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV_Q - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntMax);

  // Free-running divider, held at zero while cleared so a new word starts on a full phase.
  always_ff @(posedge sys_clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/oled_iic_writer.sv
// Fixed-format IIC write master: START, three bytes with ACK slots, STOP, then write_done.
module oled_iic_writer
  import oled_iic_pkg::*;
#(
  parameter int unsigned DIV_Q = 125
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic [23:0] wr_data,
  input  logic        iic_sda_in,
  output logic        iic_scl,
  output logic        iic_sda_oe,
  output logic        write_done,
  output logic        busy,
  output logic        ack_err
);

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic        ph_first_q, ph_first_d;
  logic        ack_err_q, ack_err_d;
  logic        scl_q, scl_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, done_q;
  logic        tick;
  logic        sym_end;

  oled_iic_tick #(
    .DIV_Q(DIV_Q)
  ) u_tick (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .clr    (state_q == StIdle),
    .tick   (tick)
  );

  assign sym_end = tick && (phase_q == PH3);

  // Next-state: symbol sequencing, shifting and ACK sampling.
  always_comb begin
    state_d    = state_q;
    phase_d    = tick ? phase_q + 2'd1 : phase_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    ack_err_d  = ack_err_q;
    // Marks the first clock of each phase.
    ph_first_d = tick;
    case (state_q)
      StIdle: begin
        if (wr_req) begin
          state_d    = StStart;
          phase_d    = PH0;
          bit_cnt_d  = 4'd0;
          byte_cnt_d = 2'd0;
          shift_d    = wr_data;
          ack_err_d  = 1'b0;
        end
      end
      StStart: begin
        if (sym_end) begin
          state_d   = StByte;
          bit_cnt_d = 4'd0;
        end
      end
      StByte: begin
        if (sym_end) begin
          shift_d = {shift_q[22:0], 1'b0};
          if (bit_cnt_q == 4'd7) begin
            state_d   = StAck;
            bit_cnt_d = 4'd8;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StAck: begin
        if ((phase_q == PH2) && ph_first_q && iic_sda_in) begin
          ack_err_d = 1'b1;
        end
        if (sym_end) begin
          if (byte_cnt_q == 2'd2) begin
            state_d = StStop;
          end else begin
            state_d    = StByte;
            bit_cnt_d  = 4'd0;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      StStop: begin
        if (sym_end) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Bus levels decoded from next state so the pads are registered and aligned with state_q.
    {scl_d, sda_oe_d} = bus_levels(state_d, phase_d, shift_d[23]);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      phase_q    <= PH0;
      bit_cnt_q  <= 4'd0;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      ph_first_q <= 1'b0;
      ack_err_q  <= 1'b0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      ph_first_q <= ph_first_d;
      ack_err_q  <= ack_err_d;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
    end
  end

  assign iic_scl    = scl_q;
  assign iic_sda_oe = sda_oe_q;
  assign write_done = done_q;
  assign busy       = busy_q;
  assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_oled_iic_writer.sv
// Bench for oled_iic_writer: IIC slave model, bus decoder/protocol monitor and a
// scoreboard of expected frames and write_done events.
module tb_oled_iic_writer;
  import oled_iic_pkg::*;

  localparam int unsigned DivQ = 4;
  // write_done is sampled high by the clock edge accept + 116*DivQ + 1.
  localparam int DoneLat = 116 * DivQ + 1;

  typedef struct {
    logic [23:0] word;
    int          nack;
  } frame_t;

  typedef struct {
    int   cyc;
    logic ack_err;
  } done_t;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        wr_req  = 1'b0;
  logic [23:0] wr_data = 24'd0;
  logic        iic_sda_in;
  logic        iic_scl;
  logic        iic_sda_oe;
  logic        write_done;
  logic        busy;
  logic        ack_err;
  logic        slave_low = 1'b0;

  assign iic_sda_in = ~(iic_sda_oe | slave_low);

  oled_iic_writer #(
    .DIV_Q(DivQ)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .iic_sda_in(iic_sda_in),
    .iic_scl   (iic_scl),
    .iic_sda_oe(iic_sda_oe),
    .write_done(write_done),
    .busy      (busy),
    .ack_err   (ack_err)
  );

  always #5 sys_clk = ~sys_clk;

  // cyc equals the index of the most recent rising edge.
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int     errors = 0;
  int     checks = 0;
  frame_t exp_frames[$];
  done_t  exp_done[$];
  int     nack_sel = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- bus monitor and slave model ----------------
  logic        mon_en   = 1'b0;
  logic        abort    = 1'b0;
  logic        in_frame = 1'b0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        sda_now;
  int          bitn     = 0;
  int          byten    = 0;
  int          lvl_cnt  = 100;
  int          viol     = 0;
  logic [7:0]  cur;
  logic [23:0] got;
  logic [2:0]  acks;
  logic [2:0]  exp_acks;
  frame_t      fr;

  always @(negedge sys_clk) begin
    sda_now = iic_sda_in;
    if (!mon_en) begin
      prev_scl = iic_scl;
      prev_sda = sda_now;
    end else if (!rst_n) begin
      in_frame  = 1'b0;
      slave_low = 1'b0;
      abort     = 1'b1;
      prev_scl  = iic_scl;
      prev_sda  = ~iic_sda_oe;
    end else begin
      // SDA edges while SCL is high: START, STOP or a protocol violation.
      if (iic_scl && prev_scl && (sda_now != prev_sda)) begin
        if (!sda_now && !in_frame) begin
          in_frame = 1'b1;
          abort    = 1'b0;
          bitn     = 0;
          byten    = 0;
          got      = '0;
          acks     = '0;
        end else if (sda_now && in_frame && byten == 3 && bitn == 0) begin
          in_frame = 1'b0;
          check("frame_expected", 32'(exp_frames.size() != 0), 32'd1);
          if (exp_frames.size() != 0) begin
            fr       = exp_frames.pop_front();
            exp_acks = '0;
            if (fr.nack >= 0) exp_acks[fr.nack] = 1'b1;
            check("frame_bytes", 32'(got), 32'(fr.word));
            check("frame_acks", 32'(acks), 32'(exp_acks));
            check("protocol_viol", 32'(viol), 32'd0);
          end
        end else if (!abort) begin
          viol++;
        end
      end
      // SCL high and low times must each last at least two phases.
      if (iic_scl != prev_scl) begin
        if (!abort && lvl_cnt < 2 * int'(DivQ)) viol++;
        lvl_cnt = 1;
      end else begin
        lvl_cnt++;
      end
      if (in_frame && iic_scl && !prev_scl && byten < 3) begin
        if (bitn < 8) begin
          cur = {cur[6:0], sda_now};
          bitn++;
        end else begin
          acks[byten] = sda_now;
          got         = {got[15:0], cur};
          byten++;
          bitn        = 0;
        end
      end
      if (in_frame && !iic_scl && prev_scl) begin
        slave_low = (bitn == 8) && (byten != nack_sel);
      end
      prev_scl = iic_scl;
      prev_sda = ~(iic_sda_oe | slave_low);
    end
  end

  // write_done checker.
  done_t dn;
  always @(negedge sys_clk) begin
    if (mon_en && rst_n && write_done === 1'b1) begin
      check("done_expected", 32'(exp_done.size() != 0), 32'd1);
      if (exp_done.size() != 0) begin
        dn = exp_done.pop_front();
        check("done_cycle", 32'(cyc + 1), 32'(dn.cyc));
        check("done_ack_err", 32'(ack_err), 32'(dn.ack_err));
        check("done_busy", 32'(busy), 32'd1);
      end
    end
  end

  // ---------------- stimulus ----------------
  int accept;

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Raise wr_req just after an edge; the DUT is idle, so the next edge accepts.
  task automatic issue(input logic [23:0] w, input int nack, input logic ack_e);
    frame_t f;
    done_t  d;
    @(posedge sys_clk);
    #1;
    wr_data = w;
    wr_req  = 1'b1;
    accept  = cyc + 1;
    f.word  = w;
    f.nack  = nack;
    exp_frames.push_back(f);
    d.cyc     = accept + DoneLat;
    d.ack_err = ack_e;
    exp_done.push_back(d);
  endtask

  task automatic drop_req();
    @(posedge sys_clk);
    #1;
    wr_req = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (write_done !== 1'b1 && n < bound);
    check("done_seen", 32'(write_done), 32'd1);
  endtask

  logic [23:0] stream_w[3];
  done_t       sd;
  frame_t      sf;

  initial begin
    stream_w[0] = {OLED_ADDR, CTRL_DATA, 8'h01};
    stream_w[1] = {OLED_ADDR, CTRL_DATA, 8'h02};
    stream_w[2] = {OLED_ADDR, CTRL_DATA, 8'hFF};

    // Reset state.
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_scl", 32'(iic_scl), 32'd1);
    check("rst_sda_oe", 32'(iic_sda_oe), 32'd0);
    check("rst_done", 32'(write_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(posedge sys_clk);

    // Single command.
    issue({OLED_ADDR, CTRL_CMD, 8'hB3}, -1, 1'b0);
    drop_req();
    @(negedge sys_clk);
    check("single_busy", 32'(busy), 32'd1);
    wait_done(600);
    repeat (5) @(negedge sys_clk);
    check("single_idle_busy", 32'(busy), 32'd0);
    check("single_ack_err", 32'(ack_err), 32'd0);

    // Data stream with wr_req held and data stepped on each write_done.
    issue(stream_w[0], -1, 1'b0);
    for (int i = 1; i < 3; i++) begin
      sf.word = stream_w[i];
      sf.nack = -1;
      exp_frames.push_back(sf);
      sd.cyc     = accept + i * (DoneLat + 1) + DoneLat;
      sd.ack_err = 1'b0;
      exp_done.push_back(sd);
    end
    for (int i = 0; i < 3; i++) begin
      wait_done(600);
      @(posedge sys_clk);
      #1;
      if (i < 2) wr_data = stream_w[i + 1];
      else wr_req = 1'b0;
    end
    wait_until(cyc + 500);
    check("stream_frames_left", 32'(exp_frames.size()), 32'd0);
    check("stream_busy", 32'(busy), 32'd0);

    // NACK on byte 1; transfer still completes.
    nack_sel = 1;
    issue({OLED_ADDR, CTRL_DATA, 8'hAA}, 1, 1'b1);
    drop_req();
    wait_until(accept + 250);
    check("nack_before", 32'(ack_err), 32'd0);
    wait_until(accept + 320);
    check("nack_after", 32'(ack_err), 32'd1);
    wait_done(600);
    repeat (10) @(negedge sys_clk);
    check("nack_sticky", 32'(ack_err), 32'd1);
    nack_sel = -1;

    // Inputs toggled while busy must not disturb the word in flight.
    issue({OLED_ADDR, CTRL_CMD, 8'hE7}, -1, 1'b0);
    wait_until(accept + 5);
    check("busy_ack_err_cleared", 32'(ack_err), 32'd0);
    for (int i = 0; i < 60; i++) begin
      wr_data = 24'($urandom);
      wr_req  = ~wr_req;
      @(posedge sys_clk);
      #1;
    end
    wr_req = 1'b0;
    wait_until(accept + 100);
    check("busy_mid", 32'(busy), 32'd1);
    wait_done(600);
    wait_until(cyc + 500);
    check("busy_frames_left", 32'(exp_frames.size()), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);

    // Reset during byte 1 drops the word without a STOP or write_done.
    issue({OLED_ADDR, CTRL_CMD, 8'hC5}, -1, 1'b0);
    drop_req();
    wait_until(accept + 200);
    rst_n = 1'b0;
    exp_frames.delete();
    exp_done.delete();
    wait_until(accept + 201);
    rst_n = 1'b1;
    @(negedge sys_clk);
    check("midrst_scl", 32'(iic_scl), 32'd1);
    check("midrst_sda_oe", 32'(iic_sda_oe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(write_done), 32'd0);
    wait_until(accept + 700);
    issue({OLED_ADDR, CTRL_DATA, 8'h5A}, -1, 1'b0);
    drop_req();
    wait_done(600);
    repeat (20) @(negedge sys_clk);

    check("end_frames_left", 32'(exp_frames.size()), 32'd0);
    check("end_done_left", 32'(exp_done.size()), 32'd0);
    check("end_protocol_viol", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
